// File: rtl/gps_nmea_rx.sv
// gps_nmea_rx
//   GPS front end: 8N1 UART receiver, NMEA-0183 sentence framer and checksum
//   checker. One selectable sentence type (or any type) is captured into a
//   flat MSB-first byte buffer that only changes when a sentence commits.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous reset, active high
//   data_rx      UART serial input, idle high, asynchronous
//   match_any    1: accept any sentence ID, 0: only SENT_ID (sampled at '$')
//   rx_byte      last UART byte received
//   rx_int       1-cycle pulse: rx_byte updated
//   frame_err    1-cycle pulse: stop bit sampled low, byte dropped
//   data_rx_end  last good payload, byte 0 in [8*MAX_LEN-1 -: 8], tail zeroed
//   sent_len     byte count of data_rx_end
//   sent_valid   1-cycle pulse: data_rx_end/sent_len updated
//   cs_err       1-cycle pulse: checksum mismatch or bad hex digit
//   ovf          1-cycle pulse: payload exceeded MAX_LEN, sentence dropped
module gps_nmea_rx #(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned BAUD    = 9600,
  parameter int unsigned MAX_LEN = 48,
  parameter logic [39:0] SENT_ID = "GPRMC"
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   data_rx,
  input  logic                   match_any,
  output logic [7:0]             rx_byte,
  output logic                   rx_int,
  output logic                   frame_err,
  output logic [8*MAX_LEN-1:0]   data_rx_end,
  output logic [7:0]             sent_len,
  output logic                   sent_valid,
  output logic                   cs_err,
  output logic                   ovf
);

  localparam int unsigned DIV  = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int unsigned HALF = DIV / 2;
  localparam int unsigned CW   = $clog2(DIV + 1);
  localparam int unsigned BW   = 8 * MAX_LEN;

  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_STAR   = 8'h2A;

  // ---------------------------------------------------------------------------
  // UART receiver
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} u_state_t;

  u_state_t      u_state;
  logic          sync1, sync2, sync3;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      u_state   <= U_IDLE;
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      sync3     <= 1'b1;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_byte   <= '0;
      rx_int    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync1     <= data_rx;
      sync2     <= sync1;
      sync3     <= sync2;
      rx_int    <= 1'b0;
      frame_err <= 1'b0;
      case (u_state)
        U_IDLE: begin
          cnt <= '0;
          if (sync3 && !sync2) u_state <= U_START;
        end
        U_START: begin
          // Mid-start-bit recheck rejects short glitches on the idle line.
          if (cnt == CW'(HALF - 1)) begin
            cnt <= '0;
            if (sync2) begin
              u_state <= U_IDLE;
            end else begin
              bit_idx <= '0;
              u_state <= U_DATA;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        U_DATA: begin
          if (cnt == CW'(DIV - 1)) begin
            cnt     <= '0;
            shreg   <= {sync2, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) u_state <= U_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        U_STOP: begin
          if (cnt == CW'(DIV - 1)) begin
            cnt     <= '0;
            u_state <= U_IDLE;
            if (sync2) begin
              rx_byte <= shreg;
              rx_int  <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: u_state <= U_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // NMEA framer and checksum
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {F_IDLE, F_ID, F_BODY, F_CS1, F_CS2} f_state_t;

  f_state_t       f_state;
  logic [BW-1:0]  wbuf;
  logic [7:0]     wr_ptr;
  logic [7:0]     acc;
  logic [31:0]    id_sr;
  logic           any_l;
  logic [3:0]     cs_hi;
  logic           commit;
  logic [4:0]     hex_now;
  logic [7:0]     tail_bytes;
  logic [BW-1:0]  aligned;

  // {valid, nibble} for an ASCII hex digit.
  function automatic logic [4:0] hex_dec(input logic [7:0] c);
    logic [4:0] r;
    r = '0;
    if (c >= 8'h30 && c <= 8'h39)      r = {1'b1, c[3:0]};
    else if (c >= 8'h41 && c <= 8'h46) r = {1'b1, c[3:0] + 4'd9};
    else if (c >= 8'h61 && c <= 8'h66) r = {1'b1, c[3:0] + 4'd9};
    return r;
  endfunction

  // The working buffer shifts bytes in at the bottom; on commit it is moved
  // up so byte 0 lands in the top lane and the unused tail is zero.
  always_comb begin
    hex_now    = hex_dec(rx_byte);
    tail_bytes = 8'(MAX_LEN) - wr_ptr;
    aligned    = wbuf << {tail_bytes, 3'b000};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f_state     <= F_IDLE;
      wbuf        <= '0;
      wr_ptr      <= '0;
      acc         <= '0;
      id_sr       <= '0;
      any_l       <= 1'b0;
      cs_hi       <= '0;
      commit      <= 1'b0;
      data_rx_end <= '0;
      sent_len    <= '0;
      sent_valid  <= 1'b0;
      cs_err      <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      sent_valid <= 1'b0;
      cs_err     <= 1'b0;
      ovf        <= 1'b0;
      commit     <= 1'b0;

      if (commit) begin
        data_rx_end <= aligned;
        sent_len    <= wr_ptr;
        sent_valid  <= 1'b1;
      end

      if (rx_int) begin
        if (rx_byte == CH_DOLLAR) begin
          // '$' always (re)starts a sentence, whatever state we were in.
          f_state <= F_ID;
          wr_ptr  <= '0;
          acc     <= '0;
          wbuf    <= '0;
          any_l   <= match_any;
        end else begin
          case (f_state)
            F_IDLE: begin
              f_state <= F_IDLE;
            end
            F_ID: begin
              wbuf   <= {wbuf[BW-9:0], rx_byte};
              acc    <= acc ^ rx_byte;
              wr_ptr <= wr_ptr + 8'd1;
              id_sr  <= {id_sr[23:0], rx_byte};
              if (wr_ptr == 8'd4) begin
                if (!any_l && ({id_sr, rx_byte} != SENT_ID)) f_state <= F_IDLE;
                else                                         f_state <= F_BODY;
              end
            end
            F_BODY: begin
              if (rx_byte == CH_STAR) begin
                f_state <= F_CS1;
              end else if (wr_ptr == 8'(MAX_LEN)) begin
                ovf     <= 1'b1;
                f_state <= F_IDLE;
              end else begin
                wbuf   <= {wbuf[BW-9:0], rx_byte};
                acc    <= acc ^ rx_byte;
                wr_ptr <= wr_ptr + 8'd1;
              end
            end
            F_CS1: begin
              if (hex_now[4]) begin
                cs_hi   <= hex_now[3:0];
                f_state <= F_CS2;
              end else begin
                cs_err  <= 1'b1;
                f_state <= F_IDLE;
              end
            end
            F_CS2: begin
              f_state <= F_IDLE;
              if (hex_now[4] && ({cs_hi, hex_now[3:0]} == acc)) commit <= 1'b1;
              else                                              cs_err <= 1'b1;
            end
            default: f_state <= F_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_gps_nmea_rx.sv
// tb_gps_nmea_rx
//   Directed bench for gps_nmea_rx with a fast bit clock (DIV = 10) and an
//   80-bit payload buffer so sentences fit in a short run.
module tb_gps_nmea_rx;

  localparam int unsigned DIV     = 10;
  localparam int unsigned MAX_LEN = 10;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 data_rx = 1'b1;
  logic                 match_any = 1'b0;
  logic [7:0]           rx_byte;
  logic                 rx_int;
  logic                 frame_err;
  logic [8*MAX_LEN-1:0] data_rx_end;
  logic [7:0]           sent_len;
  logic                 sent_valid;
  logic                 cs_err;
  logic                 ovf;

  gps_nmea_rx #(
    .CLK_HZ  (1_000_000),
    .BAUD    (100_000),
    .MAX_LEN (MAX_LEN),
    .SENT_ID ("GPRMC")
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .data_rx     (data_rx),
    .match_any   (match_any),
    .rx_byte     (rx_byte),
    .rx_int      (rx_int),
    .frame_err   (frame_err),
    .data_rx_end (data_rx_end),
    .sent_len    (sent_len),
    .sent_valid  (sent_valid),
    .cs_err      (cs_err),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int n_valid = 0, n_cs = 0, n_ovf = 0, n_fe = 0, n_int = 0;
  logic [7:0] ovf_byte = '0;
  int v0, c0, o0, f0, i0;

  always @(negedge clk) begin
    if (sent_valid) n_valid <= n_valid + 1;
    if (cs_err)     n_cs    <= n_cs + 1;
    if (ovf) begin
      n_ovf    <= n_ovf + 1;
      ovf_byte <= rx_byte;
    end
    if (frame_err)  n_fe    <= n_fe + 1;
    if (rx_int)     n_int   <= n_int + 1;
  end

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic snap();
    v0 = n_valid; c0 = n_cs; o0 = n_ovf; f0 = n_fe; i0 = n_int;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    data_rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      data_rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    data_rx = stop_bit;
    repeat (DIV) @(negedge clk);
    data_rx = 1'b1;
    repeat (2 * DIV) @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + 8'(n) : 8'h41 + 8'(n) - 8'd10;
  endfunction

  // '$' + body + '*' + two hex checksum digits; corrupt bumps the low digit.
  task automatic send_sentence(input string body, input logic corrupt);
    logic [7:0] x;
    logic [3:0] lo;
    x = '0;
    for (int i = 0; i < body.len(); i++) x ^= body[i];
    lo = corrupt ? x[3:0] + 4'd1 : x[3:0];
    send_byte(8'h24, 1'b1);
    send_str(body);
    send_byte(8'h2A, 1'b1);
    send_byte(hexc(x[7:4]), 1'b1);
    send_byte(hexc(lo), 1'b1);
  endtask

  logic [79:0] exp_rmc_a, exp_gga, exp_full, exp_rmc_1;

  initial begin
    exp_rmc_a = {"GPRMC,A", 24'h0};
    exp_gga   = {"GPGGA,1", 24'h0};
    exp_full  = "GPRMC,1234";
    exp_rmc_1 = {"GPRMC,1", 24'h0};

    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    check("rst_data", data_rx_end, '0);
    check("rst_len",  80'(sent_len), '0);
    check("rst_byte", 80'(rx_byte), '0);
    check("rst_pulses", 80'({rx_int, frame_err, sent_valid, cs_err, ovf}), '0);

    // Good GPRMC sentence followed by CR LF.
    snap();
    send_sentence("GPRMC,A", 1'b0);
    send_byte(8'h0D, 1'b1);
    send_byte(8'h0A, 1'b1);
    check("t1_valid", 80'(n_valid - v0), 80'd1);
    check("t1_len",   80'(sent_len), 80'd7);
    check("t1_data",  data_rx_end, exp_rmc_a);
    check("t1_nint",  80'(n_int - i0), 80'd13);
    check("t1_last",  80'(rx_byte), 80'h0A);
    check("t1_cserr", 80'(n_cs - c0), 80'd0);

    // Wrong checksum digit.
    snap();
    send_sentence("GPRMC,A", 1'b1);
    check("t2_cserr", 80'(n_cs - c0), 80'd1);
    check("t2_valid", 80'(n_valid - v0), 80'd0);
    check("t2_data",  data_rx_end, exp_rmc_a);
    check("t2_len",   80'(sent_len), 80'd7);

    // Foreign ID, filtered then accepted.
    snap();
    match_any = 1'b0;
    send_sentence("GPGGA,1", 1'b0);
    check("t3_filt_pulses", 80'((n_valid - v0) + (n_cs - c0) + (n_ovf - o0)), 80'd0);
    check("t3_filt_data", data_rx_end, exp_rmc_a);
    snap();
    match_any = 1'b1;
    send_sentence("GPGGA,1", 1'b0);
    match_any = 1'b0;
    check("t3_any_valid", 80'(n_valid - v0), 80'd1);
    check("t3_any_data",  data_rx_end, exp_gga);
    check("t3_any_len",   80'(sent_len), 80'd7);

    // One char over the limit, then exactly the limit.
    snap();
    send_sentence("GPRMC,12345", 1'b0);
    check("t4_ovf",      80'(n_ovf - o0), 80'd1);
    check("t4_ovf_byte", 80'(ovf_byte), 80'h35);
    check("t4_valid",    80'(n_valid - v0), 80'd0);
    check("t4_data",     data_rx_end, exp_gga);
    snap();
    send_sentence("GPRMC,1234", 1'b0);
    check("t4_full_valid", 80'(n_valid - v0), 80'd1);
    check("t4_full_len",   80'(sent_len), 80'd10);
    check("t4_full_data",  data_rx_end, exp_full);
    check("t4_full_ovf",   80'(n_ovf - o0), 80'd0);

    // Framing error and idle-line glitch.
    snap();
    send_byte(8'h55, 1'b0);
    check("t5_fe",   80'(n_fe - f0), 80'd1);
    check("t5_nint", 80'(n_int - i0), 80'd0);
    snap();
    data_rx = 1'b0;
    repeat (2) @(negedge clk);
    data_rx = 1'b1;
    repeat (4 * DIV) @(negedge clk);
    check("t5_glitch_int", 80'(n_int - i0), 80'd0);
    check("t5_glitch_fe",  80'(n_fe - f0), 80'd0);

    // Restart on a second '$'.
    snap();
    send_str("$GPR");
    send_sentence("GPRMC,1", 1'b0);
    check("t6_valid", 80'(n_valid - v0), 80'd1);
    check("t6_data",  data_rx_end, exp_rmc_1);
    check("t6_len",   80'(sent_len), 80'd7);

    // Reset in the middle of a body.
    snap();
    send_str("$GPRMC,9");
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4 * DIV) @(negedge clk);
    check("t6_rst_valid", 80'(n_valid - v0), 80'd0);
    check("t6_rst_data",  data_rx_end, '0);
    check("t6_rst_len",   80'(sent_len), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
